// File: rtl/uart_core_pkg.sv
// Shared definitions for the UART core: parity modes, FSM encodings and a width helper.
package uart_core_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int cnt_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_core_fifo.sv
// Synchronous first-word-fall-through FIFO with overrun reporting; used for the RX word queue.
module uart_core_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);
  assign overrun = push & ~do_push;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: TX FSM, synchronised RX FSM with parity/framing checks, RX FIFO.
module uart_core
  import uart_core_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic                 tx_serial,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun
);
  localparam int CW      = cnt_width(CLKS_PER_BIT);
  localparam bit HAS_PAR = (PARITY_MODE != PARITY_NONE);

  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data;
  } rx_word_t;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == PARITY_ODD) ? ~^d : ^d;
  endfunction

  // ---------------- TX ----------------
  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt == CW'(CLKS_PER_BIT-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
    end else if (tx_state == TX_IDLE) begin
      if (tx_valid) begin
        tx_shift  <= tx_data;
        tx_par    <= par_of(tx_data);
        tx_cnt    <= '0;
        tx_serial <= 1'b0;
        tx_ready  <= 1'b0;
        tx_state  <= TX_START;
      end
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
      if (tx_tick) begin
        case (tx_state)
          TX_START: begin
            tx_serial <= tx_shift[0];
            tx_bit    <= '0;
            tx_state  <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit == 4'(DATA_BITS-1)) begin
              tx_bit    <= '0;
              tx_serial <= HAS_PAR ? tx_par : 1'b1;
              tx_state  <= HAS_PAR ? TX_PARITY : TX_STOP;
            end else begin
              tx_shift  <= tx_shift >> 1;
              tx_serial <= tx_shift[1];
              tx_bit    <= tx_bit + 1'b1;
            end
          end
          TX_PARITY: begin
            tx_serial <= 1'b1;
            tx_bit    <= '0;
            tx_state  <= TX_STOP;
          end
          TX_STOP: begin
            if (tx_bit == 4'(STOP_BITS-1)) begin
              tx_ready <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX ----------------
  logic                 rx_s1, rx_s2;
  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr;
  logic                 rx_push;
  rx_word_t             rx_word, rx_head;
  logic                 rx_tick, rx_empty;

  assign rx_tick = (rx_cnt == CW'(CLKS_PER_BIT-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_serial;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
      rx_push  <= 1'b0;
      rx_word  <= '0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s2) begin
            rx_perr  <= 1'b0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Half-bit recheck rejects line glitches and aligns later samples to mid-bit.
          if (rx_cnt == CW'(CLKS_PER_BIT/2-1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == 4'(DATA_BITS-1)) rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            else                           rx_bit   <= rx_bit + 1'b1;
          end
        end
        RX_PARITY: begin
          rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
          if (rx_tick) begin
            rx_perr  <= (rx_s2 != par_of(rx_shift));
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
          if (rx_tick) begin
            rx_word  <= '{frame_err: ~rx_s2, parity_err: rx_perr, data: rx_shift};
            rx_push  <= 1'b1;
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_core_fifo #(
    .WIDTH (DATA_BITS+2),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_push),
    .wdata   (rx_word),
    .pop     (rx_valid & rx_ready),
    .rdata   (rx_head),
    .empty   (rx_empty),
    .overrun (rx_overrun)
  );

  assign rx_valid      = ~rx_empty;
  assign rx_data       = rx_head.data;
  assign rx_parity_err = rx_head.parity_err;
  assign rx_frame_err  = rx_head.frame_err;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboarded bench for uart_core: TX waveform, loopback, error frames, glitch, overrun, reset.
`timescale 1ns/1ps
module tb_uart_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_serial, tx_serial;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_valid, rx_overrun;
  logic       rx_ready = 1'b0;
  logic       loop_en = 1'b0;
  logic       rx_drive = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int ovr_cnt = 0;
  logic [9:0] exp_q [$];

  assign rx_serial = loop_en ? tx_serial : rx_drive;

  always #5 clk = ~clk;

  uart_core #(
    .CLKS_PER_BIT (16),
    .DATA_BITS    (8),
    .PARITY_MODE  (2),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_serial     (rx_serial),
    .tx_serial     (tx_serial),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_overrun    (rx_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every popped word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rx_unexpected: got %0h, expected no word", {rx_frame_err, rx_parity_err, rx_data});
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({rx_frame_err, rx_parity_err, rx_data} !== e) begin
            miscompares++;
            $display("FAIL rx_word: got %0h, expected %0h", {rx_frame_err, rx_parity_err, rx_data}, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_word(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 400) begin tick(); n++; end
    if (!tx_ready) check("tx_ready_timeout", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic par_flip, input logic stop_val);
    logic [10:0] bits;
    bits = {stop_val, (^d) ^ par_flip, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      rx_drive = bits[b];
      repeat (16) tick();
    end
    rx_drive = 1'b1;
    repeat (32) tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin tick(); n++; end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [10:0] a5_bits;
    int low_cnt;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_tx_serial", 32'(tx_serial), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_overrun", 32'(rx_overrun), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);

    // TX waveform of 0xA5 with even parity: start, 1,0,1,0,0,1,0,1, P=0, stop
    a5_bits = 11'b1_0_10100101_0;
    low_cnt = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    for (int i = 0; i < 176; i++) begin
      if (!tx_ready) low_cnt++;
      if (i % 16 == 0 || i % 16 == 15) check($sformatf("tx_a5_bit%0d", i/16), 32'(tx_serial), 32'(a5_bits[i/16]));
      tick();
    end
    check("tx_ready_low_cycles", 32'(low_cnt), 32'd176);
    check("tx_ready_after_frame", 32'(tx_ready), 32'd1);
    check("tx_idle_high", 32'(tx_serial), 32'd1);

    // Loopback 0x00..0xFF back to back
    rx_ready = 1'b1;
    loop_en  = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({2'b00, 8'(i)});
      tx_word(8'(i));
    end
    drain("loopback_drain");
    check("loopback_overrun", 32'(ovr_cnt), 32'd0);
    repeat (40) tick();
    loop_en = 1'b0;
    repeat (40) tick();

    // Error frames
    exp_q.push_back({2'b10, 8'h3C});
    drive_frame(8'h3C, 1'b0, 1'b0);
    exp_q.push_back({2'b01, 8'h81});
    drive_frame(8'h81, 1'b1, 1'b1);
    exp_q.push_back({2'b00, 8'h5A});
    drive_frame(8'h5A, 1'b0, 1'b1);
    drain("errframe_drain");

    // 4-cycle glitch must not produce a word
    rx_ready = 1'b0;
    rx_drive = 1'b0;
    repeat (4) tick();
    rx_drive = 1'b1;
    repeat (60) tick();
    check("glitch_no_word", 32'(rx_valid), 32'd0);

    // Overrun: 5 words into a 4-deep FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({2'b00, 8'(8'h11 + i)});
      drive_frame(8'(8'h11 + i), 1'b0, 1'b1);
      if (i == 3) check("ovr_before_word5", 32'(ovr_cnt), 32'd0);
    end
    check("ovr_after_word5", 32'(ovr_cnt), 32'd1);
    check("ovr_fifo_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    repeat (10) tick();
    check("ovr_popped_all", 32'(exp_q.size()), 32'd0);
    check("ovr_then_empty", 32'(rx_valid), 32'd0);

    // Reset mid-TX-frame with a word sitting in the FIFO
    rx_ready = 1'b0;
    drive_frame(8'h77, 1'b0, 1'b1);
    check("pre_rst_rx_valid", 32'(rx_valid), 32'd1);
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (50) tick();
    check("mid_tx_busy", 32'(tx_ready), 32'd0);
    rst = 1'b1;
    tick();
    check("midrst_tx_serial", 32'(tx_serial), 32'd1);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
